// File: rtl/hazard_scoreboard_forwarder_pkg.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_forwarder_pkg
// Shared forwarding-select encodings for the EX-stage RAW hazard unit.
// Revision: 1.0
// ============================================================================
package hazard_scoreboard_forwarder_pkg;

  localparam int FWD_RF = 0;

  // Fixed two-stage encoding kept for existing single-pipeline users.
  typedef enum logic [1:0] {
    FWD_E_RF  = 2'd0,
    FWD_E_MEM = 2'd1,
    FWD_E_WB  = 2'd2
  } forward_e_t;

  function automatic int fwd_stage_sel(input int i);
    return i + 1;
  endfunction

  function automatic int fwd_cmpl_sel(input int n);
    return n + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_forwarder_fwd_port_select.sv
`default_nettype none
// ============================================================================
// fwd_port_select
// Priority forwarding search for one source operand; emits select and stall.
// Revision: 1.0
// ============================================================================
module fwd_port_select
  import hazard_scoreboard_forwarder_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_REGS   = 32,
  localparam int SELW      = $clog2(NUM_STAGES + 2)
) (
  input  logic [4:0]                  rs_i,
  input  logic                        used_i,
  input  logic [NUM_STAGES-1:0]       stage_regwrite_i,
  input  logic [NUM_STAGES-1:0][4:0]  stage_rd_i,
  input  logic [NUM_STAGES-1:0]       stage_ready_i,
  input  logic                        cmpl_valid_i,
  input  logic [4:0]                  cmpl_rd_i,
  input  logic [NUM_REGS-1:0]         pending_i,
  output logic [SELW-1:0]             sel_o,
  output logic                        stall_o
);

  logic active;
  logic pend_hit;
  logic found;

  assign active   = used_i && (rs_i != 5'd0);
  assign pend_hit = (int'(rs_i) < NUM_REGS) ? pending_i[rs_i] : 1'b0;

  always_comb begin
    sel_o   = SELW'(FWD_RF);
    stall_o = 1'b0;
    found   = 1'b0;
    // The youngest matching stage owns the value; an unready one blocks
    // rather than letting an older, stale copy through.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (active && !found && stage_regwrite_i[i] &&
          (stage_rd_i[i] != 5'd0) && (stage_rd_i[i] == rs_i)) begin
        found   = 1'b1;
        sel_o   = SELW'(fwd_stage_sel(i));
        stall_o = !stage_ready_i[i];
      end
    end
    if (active && !found) begin
      if (cmpl_valid_i && (cmpl_rd_i == rs_i)) begin
        sel_o = SELW'(fwd_cmpl_sel(NUM_STAGES));
      end else if (pend_hit) begin
        stall_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_forwarder.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_forwarder
// EX-stage RAW forwarding, long-latency scoreboard, WAW stall and stall counter.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard_forwarder
  import hazard_scoreboard_forwarder_pkg::*;
#(
  parameter int NUM_RS     = 2,
  parameter int NUM_STAGES = 3,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 32,
  localparam int SELW      = $clog2(NUM_STAGES + 2)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_STAGES-1:0]         stage_regwrite,
  input  logic [NUM_STAGES-1:0][4:0]    stage_rd,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  input  logic [NUM_RS-1:0][4:0]        rs_e,
  input  logic [NUM_RS-1:0]             rs_used,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic                          cmpl_valid,
  input  logic [4:0]                    cmpl_rd,
  input  logic                          flush_e,
  output logic [NUM_RS-1:0][SELW-1:0]   fwd_sel,
  output logic [NUM_RS-1:0]             fwd_hit,
  output logic                          stall_e,
  output logic [NUM_REGS-1:0]           pending,
  output logic [CNT_W-1:0]              stall_cycles
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [NUM_RS-1:0]   port_stall;
  logic                issue_pend;
  logic                waw_stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] issue_mask;
  logic [NUM_REGS-1:0] cmpl_mask;

  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    fwd_port_select #(
      .NUM_STAGES (NUM_STAGES),
      .NUM_REGS   (NUM_REGS)
    ) u_sel (
      .rs_i             (rs_e[p]),
      .used_i           (rs_used[p]),
      .stage_regwrite_i (stage_regwrite),
      .stage_rd_i       (stage_rd),
      .stage_ready_i    (stage_ready),
      .cmpl_valid_i     (cmpl_valid),
      .cmpl_rd_i        (cmpl_rd),
      .pending_i        (pending_q),
      .sel_o            (fwd_sel[p]),
      .stall_o          (port_stall[p])
    );
    assign fwd_hit[p] = (fwd_sel[p] != SELW'(FWD_RF));
  end

  assign issue_pend = (int'(issue_rd) < NUM_REGS) ? pending_q[issue_rd] : 1'b0;
  // A same-cycle completion retires the older write, so the new issue is safe.
  assign waw_stall  = issue_valid && issue_pend && !(cmpl_valid && (cmpl_rd == issue_rd));
  assign stall_e    = ((|port_stall) || waw_stall) && !flush_e;
  assign issue_fire = issue_valid && !stall_e && !flush_e && (issue_rd != 5'd0);

  always_comb begin
    issue_mask = issue_fire ? (NUM_REGS'(1) << issue_rd) : '0;
    cmpl_mask  = cmpl_valid ? (NUM_REGS'(1) << cmpl_rd) : '0;
    // Set after clear: a same-register issue and completion leaves it pending.
    pending_d    = (pending_q & ~cmpl_mask) | issue_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_e && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending      = pending_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_forwarder.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_forwarder
// Directed self-checking bench for the EX-stage hazard/forwarding unit.
// Revision: 1.0
// ============================================================================
module tb_hazard_scoreboard_forwarder;

  localparam int NUM_RS     = 2;
  localparam int NUM_STAGES = 3;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 32;
  localparam int SELW       = $clog2(NUM_STAGES + 2);
  localparam int SEL_CMPL   = NUM_STAGES + 1;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_STAGES-1:0]        stage_regwrite;
  logic [NUM_STAGES-1:0][4:0]   stage_rd;
  logic [NUM_STAGES-1:0]        stage_ready;
  logic [NUM_RS-1:0][4:0]       rs_e;
  logic [NUM_RS-1:0]            rs_used;
  logic                         issue_valid;
  logic [4:0]                   issue_rd;
  logic                         cmpl_valid;
  logic [4:0]                   cmpl_rd;
  logic                         flush_e;
  logic [NUM_RS-1:0][SELW-1:0]  fwd_sel;
  logic [NUM_RS-1:0]            fwd_hit;
  logic                         stall_e;
  logic [NUM_REGS-1:0]          pending;
  logic [CNT_W-1:0]             stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  hazard_scoreboard_forwarder #(
    .NUM_RS     (NUM_RS),
    .NUM_STAGES (NUM_STAGES),
    .NUM_REGS   (NUM_REGS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stage_regwrite (stage_regwrite),
    .stage_rd       (stage_rd),
    .stage_ready    (stage_ready),
    .rs_e           (rs_e),
    .rs_used        (rs_used),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .cmpl_valid     (cmpl_valid),
    .cmpl_rd        (cmpl_rd),
    .flush_e        (flush_e),
    .fwd_sel        (fwd_sel),
    .fwd_hit        (fwd_hit),
    .stall_e        (stall_e),
    .pending        (pending),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stage_regwrite = '0;
    stage_rd       = '0;
    stage_ready    = '1;
    rs_e           = '0;
    rs_used        = '0;
    issue_valid    = 1'b0;
    issue_rd       = 5'd0;
    cmpl_valid     = 1'b0;
    cmpl_rd        = 5'd0;
    flush_e        = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_cnt", 64'(stall_cycles), 64'd0);
    check("rst_sel", 64'(fwd_sel), 64'h0);
    check("rst_hit", 64'(fwd_hit), 64'h0);
    check("rst_stall", 64'(stall_e), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Nearest stage wins over older stage with same rd.
    idle();
    stage_regwrite = 3'b101; stage_rd[0] = 5'd5; stage_rd[2] = 5'd5;
    rs_e[0] = 5'd5; rs_used[0] = 1'b1;
    #1;
    check("near_sel", 64'(fwd_sel[0]), 64'd1);
    check("near_hit", 64'(fwd_hit[0]), 64'd1);
    check("near_stall", 64'(stall_e), 64'd0);

    // Unready load in stage0 blocks; no fall-through to stage1.
    idle();
    stage_regwrite = 3'b011; stage_rd[0] = 5'd7; stage_rd[1] = 5'd7;
    stage_ready = 3'b110; rs_e[1] = 5'd7; rs_used[1] = 1'b1;
    #1;
    check("load_stall", 64'(stall_e), 64'd1);
    check("load_no_fallthru", 64'(fwd_sel[1] == 3'd2), 64'd0);
    step();
    idle();
    stage_regwrite = 3'b010; stage_rd[1] = 5'd7;
    rs_e[1] = 5'd7; rs_used[1] = 1'b1;
    #1;
    check("load_fwd_sel", 64'(fwd_sel[1]), 64'd2);
    check("load_fwd_stall", 64'(stall_e), 64'd0);

    // Long-latency divide to x9.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    idle();
    rs_e[0] = 5'd9; rs_used[0] = 1'b1;
    #1;
    check("div_pending", 64'(pending), 64'h200);
    check("div_stall", 64'(stall_e), 64'd1);
    check("div_stall_sel", 64'(fwd_sel[0]), 64'd0);
    step();
    cmpl_valid = 1'b1; cmpl_rd = 5'd9;
    #1;
    check("cmpl_sel", 64'(fwd_sel[0]), 64'(SEL_CMPL));
    check("cmpl_hit", 64'(fwd_hit[0]), 64'd1);
    check("cmpl_stall", 64'(stall_e), 64'd0);
    step();
    idle();
    #1;
    check("cmpl_clear", 64'(pending), 64'h0);

    // WAW on x3.
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    check("waw_setup", 64'(pending), 64'h8);
    #1;
    check("waw_stall", 64'(stall_e), 64'd1);
    cmpl_valid = 1'b1; cmpl_rd = 5'd3;
    #1;
    check("waw_cmpl_nostall", 64'(stall_e), 64'd0);
    step();
    check("waw_issue_wins", 64'(pending), 64'h8);
    idle();
    cmpl_valid = 1'b1; cmpl_rd = 5'd3;
    step();
    check("waw_drain", 64'(pending), 64'h0);

    // Inactive ports: x0 reads and unused ports.
    idle();
    stage_regwrite = 3'b011; stage_rd[0] = 5'd0; stage_rd[1] = 5'd6;
    stage_ready = 3'b000;
    rs_e[0] = 5'd0; rs_used[0] = 1'b1;
    rs_e[1] = 5'd6; rs_used[1] = 1'b0;
    #1;
    check("x0_sel", 64'(fwd_sel), 64'h0);
    check("inactive_stall", 64'(stall_e), 64'd0);

    // Flush hides a hazard but keeps the scoreboard.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    idle();
    rs_e[0] = 5'd10; rs_used[0] = 1'b1;
    #1;
    check("flush_pre_stall", 64'(stall_e), 64'd1);
    flush_e = 1'b1; issue_valid = 1'b1; issue_rd = 5'd11;
    #1;
    check("flush_stall", 64'(stall_e), 64'd0);
    step();
    check("flush_pending", 64'(pending), 64'h400);

    // Counter: reset, then 40 stalled cycles, then async reset mid-stall.
    idle();
    rst_n = 1'b0;
    #1;
    check("areset_pending", 64'(pending), 64'h0);
    check("areset_cnt", 64'(stall_cycles), 64'd0);
    step();
    rst_n = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    idle();
    stage_regwrite = 3'b001; stage_rd[0] = 5'd7; stage_ready = 3'b110;
    rs_e[0] = 5'd7; rs_used[0] = 1'b1;
    #1;
    check("cnt_stall_on", 64'(stall_e), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check("cnt_40", 64'(stall_cycles), 64'd40);
    check("cnt_pending", 64'(pending), 64'h1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("cnt_reset", 64'(stall_cycles), 64'd0);
    check("cnt_reset_pending", 64'(pending), 64'h0);
    step();
    rst_n = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
